// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one operand bit per clock, LSB first, through
// two half_adder cells and a carry flop; registered sum/carry-out with start/done handshake.

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_c,
  output logic carry_c
);
  assign sum_c   = a_i ^ b_i;
  assign carry_c = a_i & b_i;
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   psum_q, psum_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               co_q, co_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               s1_c, c1_c, sum_bit_c, c2_c;

  // Full-adder slice built from two half adders on the current operand LSBs.
  half_adder u_ha0 (.a_i(a_sh_q[0]), .b_i(b_sh_q[0]), .sum_c(s1_c),      .carry_c(c1_c));
  half_adder u_ha1 (.a_i(s1_c),      .b_i(carry_q),   .sum_c(sum_bit_c), .carry_c(c2_c));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    psum_d  = psum_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    co_d    = co_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          psum_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d              = a_sh_q >> 1;
        b_sh_d              = b_sh_q >> 1;
        carry_d             = c1_c | c2_c;
        psum_d              = psum_q >> 1;
        psum_d[WIDTH-1]     = sum_bit_c;
        cnt_d               = cnt_q + CNT_W'(1);
        // Result is published on the same edge that retires the last bit.
        if (cnt_q == LAST_BIT) begin
          s_d     = psum_d;
          co_d    = carry_d;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;

endmodule
